// File: rtl/rename_dispatch_stage_pkg.sv
// rtl/rename_dispatch_stage_pkg.sv - cpu_params: shared widths, opcodes, rs classes and the uop record
package cpu_params;

    localparam int DISPATCH_WIDTH = 2;
    localparam int ARCH_REG_BITS  = 5;
    localparam int PHYS_REG_BITS  = 6;
    localparam int ROB_IDX_BITS   = 5;
    localparam int NUM_RS         = 2;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [0:0] {
        RS_INT  = 1'b0,
        RS_INTM = 1'b1
    } rs_class_t;

    // Decoded fields are captured in the stage register; the rename fields
    // (pd, ps1, ps2, old_pd, rob_idx) are filled in on the way out.
    typedef struct packed {
        rs_class_t                cls;
        logic [6:0]               opcode;
        logic [2:0]               funct3;
        logic [6:0]               funct7;
        logic                     rd_valid;
        logic [ARCH_REG_BITS-1:0] rd;
        logic [ARCH_REG_BITS-1:0] rs1;
        logic [ARCH_REG_BITS-1:0] rs2;
        logic [31:0]              imm;
        logic [31:0]              pc;
        logic [PHYS_REG_BITS-1:0] pd;
        logic [PHYS_REG_BITS-1:0] ps1;
        logic [PHYS_REG_BITS-1:0] ps2;
        logic [PHYS_REG_BITS-1:0] old_pd;
        logic [ROB_IDX_BITS-1:0]  rob_idx;
    } uop_t;

endpackage

// File: rtl/rename_dispatch_stage_id_decoder.sv
// rtl/rename_dispatch_stage_id_decoder.sv - single-lane combinational instruction to uop_t decoder
module id_decoder
    import cpu_params::*;
(
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output uop_t        o_uop
);

    logic w_writes_rd;

    always_comb begin
        o_uop        = '0;
        w_writes_rd  = 1'b1;
        o_uop.cls    = RS_INT;
        o_uop.opcode = i_inst[6:0];
        o_uop.funct3 = i_inst[14:12];
        o_uop.funct7 = i_inst[31:25];
        o_uop.rd     = i_inst[11:7];
        o_uop.rs1    = i_inst[19:15];
        o_uop.rs2    = i_inst[24:20];
        o_uop.pc     = i_pc;
        case (i_inst[6:0])
            OP_LUI, OP_AUIPC: o_uop.imm = {i_inst[31:12], 12'b0};
            OP_JAL:           o_uop.imm = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
            OP_JALR, OP_LOAD, OP_IMM:
                              o_uop.imm = {{20{i_inst[31]}}, i_inst[31:20]};
            OP_STORE: begin
                o_uop.imm   = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
                w_writes_rd = 1'b0;
            end
            OP_BRANCH: begin
                o_uop.imm   = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
                w_writes_rd = 1'b0;
            end
            OP_REG: begin
                if (i_inst[31:25] == F7_MULDIV) begin
                    o_uop.cls = RS_INTM;
                end
            end
            default: ;
        endcase
        // x0 never gets a physical register, so it never consumes a free-list entry
        o_uop.rd_valid = w_writes_rd && (i_inst[11:7] != '0);
    end

endmodule

// File: rtl/rename_dispatch_stage.sv
// rtl/rename_dispatch_stage.sv - multi-wide rename/dispatch stage; DISPATCH_PERF_EN adds stall/group counters
module rename_dispatch_stage
    import cpu_params::*;
#(
    parameter int DISPATCH_WIDTH = cpu_params::DISPATCH_WIDTH,
    parameter int ARCH_REG_BITS  = cpu_params::ARCH_REG_BITS,
    parameter int PHYS_REG_BITS  = cpu_params::PHYS_REG_BITS,
    parameter int ROB_IDX_BITS   = cpu_params::ROB_IDX_BITS,
    parameter int NUM_RS         = cpu_params::NUM_RS
)
(
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [DISPATCH_WIDTH-1:0]               fifo_valid,
    input  logic [32*DISPATCH_WIDTH-1:0]            fifo_inst,
    input  logic [32*DISPATCH_WIDTH-1:0]            fifo_pc,
    output logic                                    fifo_ready,
    output logic [ARCH_REG_BITS*DISPATCH_WIDTH-1:0] rat_rs1,
    output logic [ARCH_REG_BITS*DISPATCH_WIDTH-1:0] rat_rs2,
    input  logic [PHYS_REG_BITS*DISPATCH_WIDTH-1:0] rat_ps1,
    input  logic [PHYS_REG_BITS*DISPATCH_WIDTH-1:0] rat_ps2,
    output logic [ARCH_REG_BITS*DISPATCH_WIDTH-1:0] rat_rdo,
    input  logic [PHYS_REG_BITS*DISPATCH_WIDTH-1:0] rat_pdo,
    output logic [DISPATCH_WIDTH-1:0]               rat_we,
    output logic [ARCH_REG_BITS*DISPATCH_WIDTH-1:0] rat_rd,
    output logic [PHYS_REG_BITS*DISPATCH_WIDTH-1:0] rat_pd,
    input  logic [PHYS_REG_BITS:0]                  fl_free_cnt,
    output logic [DISPATCH_WIDTH-1:0]               fl_pop,
    input  logic [PHYS_REG_BITS*DISPATCH_WIDTH-1:0] fl_pd,
    input  logic [ROB_IDX_BITS:0]                   rob_free_cnt,
    output logic [DISPATCH_WIDTH-1:0]               rob_alloc,
    input  logic [ROB_IDX_BITS*DISPATCH_WIDTH-1:0]  rob_idx,
    input  logic [3*NUM_RS-1:0]                     rs_free_cnt,
    output logic [DISPATCH_WIDTH*NUM_RS-1:0]        rs_push,
    output uop_t [DISPATCH_WIDTH-1:0]               rs_uop,
    input  logic                                    flush
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0]                             perf_stall_fl,
    output logic [31:0]                             perf_stall_rob,
    output logic [31:0]                             perf_stall_rs,
    output logic [31:0]                             perf_groups
`endif
);

    localparam int W  = DISPATCH_WIDTH;
    localparam int AB = ARCH_REG_BITS;
    localparam int PB = PHYS_REG_BITS;
    localparam int RB = ROB_IDX_BITS;

    typedef enum logic {ST_EMPTY, ST_HELD} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_valid;
    uop_t            r_uop [W];
    uop_t            w_dec [W];
    uop_t            w_ren [W];
    logic            w_held;
    logic            w_fire;
    logic            w_load;
    logic            w_fl_ok;
    logic            w_rob_ok;
    logic            w_rs_ok;
    logic [PB:0]     w_need_pr;
    logic [RB:0]     w_need_rob;
    logic [3*NUM_RS-1:0] w_need_rs;
    int              w_slot;
    logic            w_go;

    for (genvar g = 0; g < W; g++) begin : g_dec
        id_decoder u_dec (
            .i_inst (fifo_inst[32*g +: 32]),
            .i_pc   (fifo_pc[32*g +: 32]),
            .o_uop  (w_dec[g])
        );
    end

    always_comb begin
        w_need_pr  = '0;
        w_need_rob = '0;
        w_need_rs  = '0;
        w_rs_ok    = 1'b1;
        for (int k = 0; k < W; k++) begin
            if (r_valid[k]) begin
                w_need_rob = w_need_rob + 1'b1;
                if (r_uop[k].rd_valid) begin
                    w_need_pr = w_need_pr + 1'b1;
                end
                for (int c = 0; c < NUM_RS; c++) begin
                    if (r_uop[k].cls == rs_class_t'(c)) begin
                        w_need_rs[3*c +: 3] = w_need_rs[3*c +: 3] + 3'd1;
                    end
                end
            end
        end
        for (int c = 0; c < NUM_RS; c++) begin
            if (rs_free_cnt[3*c +: 3] < w_need_rs[3*c +: 3]) begin
                w_rs_ok = 1'b0;
            end
        end
    end

    assign w_fl_ok    = (fl_free_cnt >= w_need_pr);
    assign w_rob_ok   = (rob_free_cnt >= w_need_rob);
    assign w_held     = (r_state == ST_HELD);
    assign w_fire     = w_held && !flush && w_fl_ok && w_rob_ok && w_rs_ok;
    // Nothing is popped while a flush is squashing the front end
    assign fifo_ready = !rst && !flush && (!w_held || w_fire);
    assign w_load     = fifo_ready && fifo_valid[0];

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else if (w_load) begin
            w_state_nxt = ST_HELD;
        end else if (w_fire) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_valid <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                r_valid <= '0;
            end else if (w_load) begin
                r_valid <= fifo_valid;
            end else if (w_fire) begin
                r_valid <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            for (int k = 0; k < W; k++) begin
                r_uop[k] <= w_dec[k];
            end
        end
    end

    // Free-list slots go to rd-writing lanes in lane order; sources and the
    // old mapping take the nearest earlier lane's new pd over the RAT value.
    always_comb begin
        w_slot = 0;
        for (int k = 0; k < W; k++) begin
            w_ren[k]         = r_uop[k];
            w_ren[k].pd      = '0;
            w_ren[k].ps1     = rat_ps1[PB*k +: PB];
            w_ren[k].ps2     = rat_ps2[PB*k +: PB];
            w_ren[k].old_pd  = rat_pdo[PB*k +: PB];
            w_ren[k].rob_idx = rob_idx[RB*k +: RB];
            if (r_valid[k] && r_uop[k].rd_valid) begin
                w_ren[k].pd = fl_pd[PB*w_slot +: PB];
                w_slot      = w_slot + 1;
            end
            for (int i = 0; i < k; i++) begin
                if (r_valid[i] && r_uop[i].rd_valid) begin
                    if (r_uop[i].rd == r_uop[k].rs1) w_ren[k].ps1    = w_ren[i].pd;
                    if (r_uop[i].rd == r_uop[k].rs2) w_ren[k].ps2    = w_ren[i].pd;
                    if (r_uop[i].rd == r_uop[k].rd)  w_ren[k].old_pd = w_ren[i].pd;
                end
            end
        end
    end

    always_comb begin
        fl_pop    = '0;
        rat_we    = '0;
        rob_alloc = '0;
        rs_push   = '0;
        rat_rs1   = '0;
        rat_rs2   = '0;
        rat_rdo   = '0;
        rat_rd    = '0;
        rat_pd    = '0;
        rs_uop    = '0;
        w_go      = 1'b0;
        for (int k = 0; k < W; k++) begin
            w_go                   = w_fire && r_valid[k];
            fl_pop[k]              = w_go && r_uop[k].rd_valid;
            rat_we[k]              = w_go && r_uop[k].rd_valid;
            rob_alloc[k]           = w_go;
            rat_rs1[AB*k +: AB]    = r_uop[k].rs1;
            rat_rs2[AB*k +: AB]    = r_uop[k].rs2;
            rat_rdo[AB*k +: AB]    = r_uop[k].rd;
            rat_rd[AB*k +: AB]     = r_uop[k].rd;
            rat_pd[PB*k +: PB]     = w_ren[k].pd;
            rs_uop[k]              = w_ren[k];
            for (int c = 0; c < NUM_RS; c++) begin
                rs_push[NUM_RS*k + c] = w_go && (r_uop[k].cls == rs_class_t'(c));
            end
        end
    end

`ifdef DISPATCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_fl  <= '0;
            perf_stall_rob <= '0;
            perf_stall_rs  <= '0;
            perf_groups    <= '0;
        end else begin
            if (w_held && !w_fire) begin
                if (!w_fl_ok && perf_stall_fl != '1)   perf_stall_fl  <= perf_stall_fl + 32'd1;
                if (!w_rob_ok && perf_stall_rob != '1) perf_stall_rob <= perf_stall_rob + 32'd1;
                if (!w_rs_ok && perf_stall_rs != '1)   perf_stall_rs  <= perf_stall_rs + 32'd1;
            end
            if (w_fire && perf_groups != '1) perf_groups <= perf_groups + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rename_dispatch_stage.sv
// tb/tb_rename_dispatch_stage.sv - directed self-checking bench for rename_dispatch_stage
module tb_rename_dispatch_stage;
    import cpu_params::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  fifo_valid;
    logic [63:0] fifo_inst;
    logic [63:0] fifo_pc;
    logic        fifo_ready;
    logic [9:0]  rat_rs1, rat_rs2, rat_rdo, rat_rd;
    logic [11:0] rat_ps1, rat_ps2, rat_pdo, rat_pd;
    logic [1:0]  rat_we;
    logic [6:0]  fl_free_cnt;
    logic [1:0]  fl_pop;
    logic [11:0] fl_pd;
    logic [5:0]  rob_free_cnt;
    logic [1:0]  rob_alloc;
    logic [9:0]  rob_idx;
    logic [5:0]  rs_free_cnt;
    logic [3:0]  rs_push;
    uop_t [1:0]  rs_uop;
    logic        flush;

    logic [5:0]  rat_map [32];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    rename_dispatch_stage dut (
        .clk(clk), .rst(rst), .fifo_valid(fifo_valid), .fifo_inst(fifo_inst), .fifo_pc(fifo_pc),
        .fifo_ready(fifo_ready), .rat_rs1(rat_rs1), .rat_rs2(rat_rs2), .rat_ps1(rat_ps1),
        .rat_ps2(rat_ps2), .rat_rdo(rat_rdo), .rat_pdo(rat_pdo), .rat_we(rat_we), .rat_rd(rat_rd),
        .rat_pd(rat_pd), .fl_free_cnt(fl_free_cnt), .fl_pop(fl_pop), .fl_pd(fl_pd),
        .rob_free_cnt(rob_free_cnt), .rob_alloc(rob_alloc), .rob_idx(rob_idx),
        .rs_free_cnt(rs_free_cnt), .rs_push(rs_push), .rs_uop(rs_uop), .flush(flush)
    );

    // Environment RAT: combinational reads, lane-ordered writes (higher lane wins)
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rat_map[i] <= 6'(i);
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (rat_we[k]) rat_map[rat_rd[5*k +: 5]] <= rat_pd[6*k +: 6];
            end
        end
    end

    always_comb begin
        rat_ps1 = '0;
        rat_ps2 = '0;
        rat_pdo = '0;
        for (int k = 0; k < 2; k++) begin
            rat_ps1[6*k +: 6] = rat_map[rat_rs1[5*k +: 5]];
            rat_ps2[6*k +: 6] = rat_map[rat_rs2[5*k +: 5]];
            rat_pdo[6*k +: 6] = rat_map[rat_rdo[5*k +: 5]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic group(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1);
        fifo_valid = v;
        fifo_inst  = {i1, i0};
        fifo_pc    = {32'h104, 32'h100};
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        fifo_valid = '0; fifo_inst = '0; fifo_pc = '0;
        fl_free_cnt = 7'd20; fl_pd = {6'd21, 6'd20};
        rob_free_cnt = 6'd16; rob_idx = {5'd9, 5'd8};
        rs_free_cnt = {3'd7, 3'd7};

        cyc(); #3;
        check("reset_ready", fifo_ready, 0);
        check("reset_alloc", rob_alloc, 0);

        cyc(); rst = 1'b0;
        group(2'b11, rtype(7'h00, 5'd3, 5'd1, 5'd2), rtype(7'h00, 5'd4, 5'd1, 5'd2));
        #3;
        check("empty_ready", fifo_ready, 1);
        check("empty_pop", fl_pop, 0);

        // group1 held: two independent adds fire
        cyc();
        group(2'b11, rtype(7'h00, 5'd5, 5'd1, 5'd2), rtype(7'h00, 5'd6, 5'd5, 5'd3));
        fl_pd = {6'd21, 6'd20};
        #3;
        check("g1_fl_pop", fl_pop, 2'b11);
        check("g1_rob_alloc", rob_alloc, 2'b11);
        check("g1_rs_push", rs_push, 4'b0101);
        check("g1_rat_we", rat_we, 2'b11);
        check("g1_ready", fifo_ready, 1);
        check("g1_pd0", rs_uop[0].pd, 20);
        check("g1_pd1", rs_uop[1].pd, 21);
        check("g1_rob1", rs_uop[1].rob_idx, 9);

        // group2: intra-group bypass
        cyc();
        group(2'b11, rtype(7'h00, 5'd8, 5'd1, 5'd2), rtype(7'h00, 5'd10, 5'd1, 5'd2));
        fl_pd = {6'd12, 6'd11};
        #3;
        check("g2_pd0", rs_uop[0].pd, 11);
        check("g2_ps1_bypass", rs_uop[1].ps1, 11);
        check("g2_ps2_rat", rs_uop[1].ps2, 20);
        check("g2_oldpd0", rs_uop[0].old_pd, 5);
        check("g2_pd1", rs_uop[1].pd, 12);

        // group3: short on free registers
        cyc();
        fifo_valid = 2'b00;
        fl_free_cnt = 7'd1; fl_pd = {6'd31, 6'd30};
        #3;
        check("g3_stall_pop", fl_pop, 0);
        check("g3_stall_ready", fifo_ready, 0);
        check("g3_stall_alloc", rob_alloc, 0);

        cyc();
        fl_free_cnt = 7'd2;
        group(2'b11, rtype(7'h01, 5'd11, 5'd1, 5'd2), rtype(7'h01, 5'd12, 5'd1, 5'd2));
        #3;
        check("g3_fire_pop", fl_pop, 2'b11);
        check("g3_pd1", rs_uop[1].pd, 31);
        check("g3_ready", fifo_ready, 1);

        // group4: two MULs, INTM short, INT empty irrelevant
        cyc();
        fifo_valid = 2'b00;
        rs_free_cnt = {3'd1, 3'd0};
        #3;
        check("g4_stall_push", rs_push, 0);
        check("g4_stall_ready", fifo_ready, 0);
        check("g4_stall_alloc", rob_alloc, 0);

        cyc();
        rs_free_cnt = {3'd2, 3'd0};
        group(2'b01, rtype(7'h00, 5'd13, 5'd1, 5'd2), 32'h0);
        #3;
        check("g4_fire_push", rs_push, 4'b1010);
        check("g4_fire_alloc", rob_alloc, 2'b11);

        // group5: flush wins over a ready dispatch
        cyc();
        fifo_valid = 2'b00;
        rs_free_cnt = {3'd7, 3'd7};
        flush = 1'b1;
        #3;
        check("flush_alloc", rob_alloc, 0);
        check("flush_push", rs_push, 0);
        check("flush_pop", fl_pop, 0);
        check("flush_ready", fifo_ready, 0);

        cyc();
        flush = 1'b0;
        group(2'b11, rtype(7'h00, 5'd7, 5'd1, 5'd2), rtype(7'h00, 5'd7, 5'd3, 5'd4));
        fl_pd = {6'd41, 6'd40};
        #3;
        check("post_flush_ready", fifo_ready, 1);
        check("post_flush_alloc", rob_alloc, 0);

        // group6: duplicate rd x7
        cyc();
        group(2'b11, rtype(7'h00, 5'd0, 5'd1, 5'd2), rtype(7'h00, 5'd7, 5'd7, 5'd1));
        #3;
        check("g6_fl_pop", fl_pop, 2'b11);
        check("g6_rat_we", rat_we, 2'b11);
        check("g6_pd0", rs_uop[0].pd, 40);
        check("g6_oldpd1_bypass", rs_uop[1].old_pd, 40);
        check("g6_ps1", rs_uop[1].ps1, 20);

        // group7: lane0 writes x0, lane1 reads/renames x7
        cyc();
        fifo_valid = 2'b00;
        fl_pd = {6'd51, 6'd50};
        #3;
        check("g7_fl_pop", fl_pop, 2'b10);
        check("g7_rat_we", rat_we, 2'b10);
        check("g7_pd1", rs_uop[1].pd, 50);
        check("g7_ps1_rat_x7", rs_uop[1].ps1, 41);
        check("g7_oldpd1", rs_uop[1].old_pd, 41);
        check("g7_alloc", rob_alloc, 2'b11);

        cyc(); #3;
        check("final_x7", rat_map[7], 50);
        check("final_ready", fifo_ready, 1);
        check("final_alloc", rob_alloc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rename_dispatch_stage.md
Name: rename_dispatch_stage

Overview:
- Parametrised, multi-wide successor to the single-wide decode stage.
- Pops up to DISPATCH_WIDTH instructions per cycle from the instruction queue and decodes them into an internal register stage.
- Renames them through the RAT and free list, resolving intra-group dependencies, then dispatches the whole group to the ROB and per-class reservation stations in one cycle.

Parameters:
- DISPATCH_WIDTH, 2, lanes per group (1..4)
- ARCH_REG_BITS, 5, architectural register index width
- PHYS_REG_BITS, 6, physical register index width
- ROB_IDX_BITS, 5, ROB index width
- NUM_RS, 2, reservation-station classes (0 = INT, 1 = INTM)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fifo_valid  in  DISPATCH_WIDTH  per-lane valid from instruction queue; contiguous from lane 0
- fifo_inst  in  32*DISPATCH_WIDTH  instruction words, lane 0 oldest
- fifo_pc  in  32*DISPATCH_WIDTH  PCs
- fifo_ready  out  1  group popped when fifo_ready && fifo_valid[0]
- rat_rs1/rat_rs2  out  ARCH_REG_BITS*DISPATCH_WIDTH  RAT read addresses (combinational lookup)
- rat_ps1/rat_ps2  in  PHYS_REG_BITS*DISPATCH_WIDTH  RAT read data
- rat_we  out  DISPATCH_WIDTH  RAT write enables; lane order is priority (higher lane wins)
- rat_rd  out  ARCH_REG_BITS*DISPATCH_WIDTH  RAT write addresses
- rat_pd  out  PHYS_REG_BITS*DISPATCH_WIDTH  RAT write data
- fl_free_cnt  in  PHYS_REG_BITS+1  free registers available
- fl_pop  out  DISPATCH_WIDTH  per-lane pop strobe
- fl_pd  in  PHYS_REG_BITS*DISPATCH_WIDTH  head..head+W-1 free entries
- rob_free_cnt  in  ROB_IDX_BITS+1  free ROB slots
- rob_alloc  out  DISPATCH_WIDTH  allocation strobes
- rob_idx  in  ROB_IDX_BITS*DISPATCH_WIDTH  allocated indices
- rs_free_cnt  in  3*NUM_RS  free slots per RS class (saturating at 7)
- rs_push  out  DISPATCH_WIDTH*NUM_RS  per-lane, per-class push
- rs_uop  out  uop_t*DISPATCH_WIDTH  renamed uop bus, shared by all classes
- flush  in  1  backend flush

Behaviour:
- Stage register: DISPATCH_WIDTH uop_t entries plus valid bits. States are EMPTY (no valid lanes) and HELD.
- Reset / flush: clears all valid bits next edge. All strobes are low during and after, regardless of group contents. fifo_ready is 0 in the reset cycle.
- fifo_ready = !HELD || fire. A new group is loaded on the same edge a held group dispatches; there are no bubbles at full throughput.
- Decode is combinational from fifo_inst into the register; the register captures uop class, rd, rs1, rs2, imm, pc, and rd_valid. rd_valid is 0 when rd == x0.
- need_pr = popcount(valid & rd_valid); need_rob = popcount(valid); need_rs[c] = count of valid lanes with class c.
- fire = HELD && !flush && fl_free_cnt >= need_pr && rob_free_cnt >= need_rob && rs_free_cnt[c] >= need_rs[c] for every c.
- Dispatch is all-or-nothing. A partially resourced group stalls whole.
- On fire, every strobe pulses for exactly one cycle, gated by its lane valid.
- Free-list entries are assigned in lane order, skipping lanes without rd.
- Bypass: lane j's source equals lane i's rd (i<j, rd_valid) → lane j uses lane i's new pd instead of rat_ps. The nearest earlier lane wins.
- Same rd in two lanes: both pop; RAT keeps the higher-lane pd.
- Old pd per lane is sent on the uop for ROB freeing; it is bypassed the same way.
- Latency: fifo pop to dispatch ≥1 cycle; exactly 1 when resources are available.
- Flush with fire conditions met: the flush wins and nothing is dispatched.

Optional Feature:
- DISPATCH_PERF_EN defined: adds 32-bit saturating counters perf_stall_fl, perf_stall_rob, perf_stall_rs, and perf_groups, exposed as output ports.
  - Each stall counter increments in HELD && !fire cycles where its own resource is short; simultaneous shortages increment each.
  - All counters clear on rst.
- DISPATCH_PERF_EN undefined: the ports and logic are absent.

Decomposition:
- cpu_params package holds: uop_t, rs_class_t enum (RS_INT, RS_INTM), DISPATCH_WIDTH default, and opcode constants.
- One sub-module, id_decoder: a single-lane combinational instruction→uop_t decoder, instantiated DISPATCH_WIDTH times.

Test Plan:
- Two independent ADDs, all resources plentiful → one cycle after pop: fl_pop=2'b11, rob_alloc=2'b11, rs_push INT lanes 0,1; next group accepted the same cycle.
- Lane0 `add x5,x1,x2`, lane1 `add x6,x5,x3`, fl_pd={12,11} → lane0 pd=11; lane1 ps1=11, not rat_ps1.
- fl_free_cnt=1 with a two-rd group → no strobes, fifo_ready=0, group held; raise to 2 → fires next edge.
- rs_free_cnt INTM=1, group with two MULs → stall; INT free count is irrelevant.
- Flush asserted while HELD and resources ready → no strobes; stage EMPTY next cycle.
- Lanes with rd=x0 and a duplicate rd=x7 → fl_pop only on the x7 lanes; RAT final x7 = lane1 pd.
